// File: rtl/mandebrot_pll_pkg.sv
// Shared types and sizing helpers for the system-PLL reset/lock sequencer.
package mandebrot_pll_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } pll_state_e;

  localparam int LOST_W = 8;
  localparam logic [LOST_W-1:0] LOST_MAX = 8'hFF;

  // One shared timer serves every counting state; it only has to hold
  // (largest cycle budget - 1) because each state leaves on its last edge.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  function automatic int retry_width(input int max_retry);
    return (max_retry < 1) ? 1 : $clog2(max_retry + 1);
  endfunction

endpackage

// File: rtl/mandebrot_pll_lock_seq_if.sv
// Signal bundle between the PLL lock sequencer and the PLL / system reset tree.
interface mandebrot_pll_lock_seq_if
  import mandebrot_pll_pkg::*;
#(
  parameter int MAX_RETRY = 3
);

  localparam int RETRY_W = retry_width(MAX_RETRY);

  // pll_locked is a level, asynchronous to refclk. relock_req is a one-cycle
  // refclk strobe with no acknowledge: acted on in RUN or FAULT, dropped elsewhere.
  logic               pll_locked;
  logic               relock_req;
  logic               pll_rst;
  logic               sys_rst;
  logic               ready;
  logic               fault;
  logic [RETRY_W-1:0] retry_cnt;
  logic [LOST_W-1:0]  lost_cnt;
  logic [2:0]         state_o;

  modport master (
    input  pll_locked, relock_req,
    output pll_rst, sys_rst, ready, fault, retry_cnt, lost_cnt, state_o
  );

  modport slave (
    output pll_locked, relock_req,
    input  pll_rst, sys_rst, ready, fault, retry_cnt, lost_cnt, state_o
  );

endinterface

// File: rtl/mandebrot_sync2.sv
// Generic two-flop synchronizer, cleared to zero by the asynchronous reset.
module mandebrot_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mandebrot_pll_lock_seq.sv
// Reset/lock sequencer for the plotter's system PLL: pulses the PLL reset,
// qualifies lock, and releases the system reset only after lock is stable.
module mandebrot_pll_lock_seq
  import mandebrot_pll_pkg::*;
#(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int LOCK_STABLE  = 1024,
  parameter int MAX_RETRY    = 3
) (
  input  logic                     refclk,
  input  logic                     rst,
  mandebrot_pll_lock_seq_if.master bus
);

  localparam int TIMER_W = cnt_width(RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE);
  localparam int RETRY_W = retry_width(MAX_RETRY);

  localparam logic [TIMER_W-1:0] RST_LAST     = TIMER_W'(RST_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] STABLE_LAST  = TIMER_W'(LOCK_STABLE - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRY);

  pll_state_e         state_q, state_n;
  logic [TIMER_W-1:0] timer_q, timer_n;
  logic [RETRY_W-1:0] retry_q, retry_n;
  logic [LOST_W-1:0]  lost_q, lost_n;
  logic               locked_s;

  logic pll_rst_q, pll_rst_n;
  logic sys_rst_q, sys_rst_n;
  logic ready_q, ready_n;
  logic fault_q, fault_n;

  mandebrot_sync2 #(.W(1)) u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (bus.pll_locked),
    .q   (locked_s)
  );

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_PLL_RST;
      timer_q   <= '0;
      retry_q   <= '0;
      lost_q    <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_n;
      timer_q   <= timer_n;
      retry_q   <= retry_n;
      lost_q    <= lost_n;
      pll_rst_q <= pll_rst_n;
      sys_rst_q <= sys_rst_n;
      ready_q   <= ready_n;
      fault_q   <= fault_n;
    end
  end

  // Each counting state leaves on the edge that completes its cycle budget,
  // so the timer value on that edge is budget-1 and it never wraps.
  always_comb begin
    state_n = state_q;
    timer_n = timer_q + TIMER_W'(1);
    retry_n = retry_q;
    lost_n  = lost_q;

    unique case (state_q)
      ST_PLL_RST: begin
        if (timer_q == RST_LAST) begin
          state_n = ST_WAIT_LOCK;
        end
      end

      ST_WAIT_LOCK: begin
        if (locked_s) begin
          state_n = ST_STABLE;
        end else if (timer_q == TIMEOUT_LAST) begin
          if (retry_q < RETRY_LIMIT) begin
            retry_n = retry_q + RETRY_W'(1);
            state_n = ST_PLL_RST;
          end else begin
            state_n = ST_FAULT;
          end
        end
      end

      ST_STABLE: begin
        if (!locked_s) begin
          state_n = ST_WAIT_LOCK;
        end else if (timer_q == STABLE_LAST) begin
          state_n = ST_RUN;
        end
      end

      // Lock loss wins over a simultaneous software request so it is counted.
      ST_RUN: begin
        timer_n = '0;
        if (!locked_s) begin
          state_n = ST_PLL_RST;
          if (lost_q != LOST_MAX) begin
            lost_n = lost_q + LOST_W'(1);
          end
        end else if (bus.relock_req) begin
          state_n = ST_PLL_RST;
        end
      end

      ST_FAULT: begin
        timer_n = '0;
        if (bus.relock_req) begin
          state_n = ST_PLL_RST;
          retry_n = '0;
        end
      end

      default: begin
        state_n = ST_PLL_RST;
        timer_n = '0;
      end
    endcase

    if (state_n != state_q) begin
      timer_n = '0;
    end
    if (state_n == ST_RUN) begin
      retry_n = '0;
    end
  end

  // Outputs are decoded from the next state so they change on the same edge
  // as the state register.
  always_comb begin
    pll_rst_n = (state_n == ST_PLL_RST) || (state_n == ST_FAULT);
    sys_rst_n = (state_n != ST_RUN);
    ready_n   = (state_n == ST_RUN);
    fault_n   = (state_n == ST_FAULT);
  end

  assign bus.pll_rst   = pll_rst_q;
  assign bus.sys_rst   = sys_rst_q;
  assign bus.ready     = ready_q;
  assign bus.fault     = fault_q;
  assign bus.retry_cnt = retry_q;
  assign bus.lost_cnt  = lost_q;
  assign bus.state_o   = state_q;

endmodule

// File: tb/tb_mandebrot_pll_lock_seq.sv
// Bench for the PLL lock sequencer: directed scenarios plus random lock noise,
// checked every cycle against a phase/age model of the sequencing rules.
module tb_mandebrot_pll_lock_seq;

  localparam int RST_CYCLES   = 4;
  localparam int LOCK_TIMEOUT = 32;
  localparam int LOCK_STABLE  = 8;
  localparam int MAX_RETRY    = 2;
  localparam int VW           = 17;

  // ---------------- clock / reset ----------------
  logic refclk = 1'b0;
  logic rst;
  always #10 refclk = ~refclk;

  mandebrot_pll_lock_seq_if #(.MAX_RETRY(MAX_RETRY)) bus ();

  mandebrot_pll_lock_seq #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .LOCK_STABLE  (LOCK_STABLE),
    .MAX_RETRY    (MAX_RETRY)
  ) dut (
    .refclk (refclk),
    .rst    (rst),
    .bus    (bus)
  );

  // ---------------- behavioural model ----------------
  // phase uses the published encodings; age = edges already spent in phase.
  int m_phase, m_age, m_retry, m_lost;
  bit m_s1, m_s2;
  bit model_live = 1'b0;
  logic [VW-1:0] exp_q[$];

  function automatic void model_reset();
    m_phase = 0; m_age = 0; m_retry = 0; m_lost = 0; m_s1 = 0; m_s2 = 0;
  endfunction

  function automatic void model_step(input bit lock_in, input bit req);
    bit seen;
    int nxt;
    seen = m_s2;
    nxt  = m_phase;
    m_age++;
    case (m_phase)
      0: if (m_age == RST_CYCLES) nxt = 1;
      1: begin
        if (seen) nxt = 2;
        else if (m_age == LOCK_TIMEOUT) begin
          if (m_retry < MAX_RETRY) begin m_retry++; nxt = 0; end
          else nxt = 4;
        end
      end
      2: begin
        if (!seen) nxt = 1;
        else if (m_age == LOCK_STABLE) nxt = 3;
      end
      3: begin
        if (!seen) begin if (m_lost < 255) m_lost++; nxt = 0; end
        else if (req) nxt = 0;
      end
      4: if (req) begin m_retry = 0; nxt = 0; end
      default: nxt = 0;
    endcase
    if (nxt != m_phase) begin
      m_phase = nxt;
      m_age   = 0;
      if (nxt == 3) m_retry = 0;
    end
    m_s2 = m_s1;
    m_s1 = lock_in;
  endfunction

  function automatic logic [VW-1:0] model_vec();
    logic [VW-1:0] v;
    v = {(m_phase == 0 || m_phase == 4), (m_phase != 3), (m_phase == 3),
         (m_phase == 4), 2'(m_retry), 8'(m_lost), 3'(m_phase)};
    return v;
  endfunction

  always @(posedge refclk or posedge rst) begin
    if (rst) model_reset();
    else     model_step(bus.pll_locked, bus.relock_req);
    exp_q.delete();
    exp_q.push_back(model_vec());
    model_live = 1'b1;
  end

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  string lit_name[$];
  int    lit_field[$], lit_got[$], lit_val[$];
  int    lit_rd = 0;

  function automatic logic [VW-1:0] dut_vec();
    return {bus.pll_rst, bus.sys_rst, bus.ready, bus.fault,
            bus.retry_cnt, bus.lost_cnt, bus.state_o};
  endfunction

  function automatic int dut_field(input int f, input int supplied);
    case (f)
      0: return int'(bus.pll_rst);
      1: return int'(bus.sys_rst);
      2: return int'(bus.ready);
      3: return int'(bus.fault);
      4: return int'(bus.retry_cnt);
      5: return int'(bus.lost_cnt);
      6: return int'(bus.state_o);
      default: return supplied;
    endcase
  endfunction

  always @(negedge refclk) begin
    logic [VW-1:0] e, g;
    int got;
    if (model_live) begin
      n_cmp++;
      if (exp_q.size() != 1) begin
        n_fail++;
        $display("FAIL model_queue t=%0t size=%0d required=1", $time, exp_q.size());
      end else begin
        e = exp_q[0];
        g = dut_vec();
        if (g !== e) begin
          n_fail++;
          $display("FAIL cycle t=%0t got pll_rst=%b sys_rst=%b ready=%b fault=%b retry=%0d lost=%0d state=%0d required pll_rst=%b sys_rst=%b ready=%b fault=%b retry=%0d lost=%0d state=%0d",
                   $time, g[16], g[15], g[14], g[13], g[12:11], g[10:3], g[2:0],
                   e[16], e[15], e[14], e[13], e[12:11], e[10:3], e[2:0]);
        end
      end
    end
    while (lit_rd < lit_name.size()) begin
      got = dut_field(lit_field[lit_rd], lit_got[lit_rd]);
      n_cmp++;
      if (got != lit_val[lit_rd]) begin
        n_fail++;
        $display("FAIL %s t=%0t got=%0d required=%0d", lit_name[lit_rd], $time, got, lit_val[lit_rd]);
      end
      lit_rd++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge refclk);
      #1;
    end
  endtask

  task automatic expect_lit(input string name, input int field, input int val, input int supplied = 0);
    lit_name.push_back(name);
    lit_field.push_back(field);
    lit_got.push_back(supplied);
    lit_val.push_back(val);
  endtask

  task automatic wait_state(input int s, input int budget, input string name);
    int k;
    k = 0;
    while (int'(bus.state_o) != s && k < budget) begin
      tick();
      k++;
    end
    expect_lit(name, 7, 1, (int'(bus.state_o) == s) ? 1 : 0);
  endtask

  task automatic pulse_relock();
    bus.relock_req = 1'b1;
    tick();
    bus.relock_req = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int g, pulses, maxr, prev;
    rst = 1'b1;
    bus.pll_locked = 1'b0;
    bus.relock_req = 1'b0;
    tick(3);
    expect_lit("reset_pll_rst", 0, 1);
    expect_lit("reset_state", 6, 0);

    // Bring-up: release after edge 0, lock first sampled on edge 10.
    rst = 1'b0;
    tick(3);
    expect_lit("bringup_pll_rst_e3", 0, 1);
    tick();
    expect_lit("bringup_pll_rst_e4", 0, 0);
    expect_lit("bringup_state_e4", 6, 1);
    tick(5);
    bus.pll_locked = 1'b1;
    tick(10);
    expect_lit("bringup_ready_e19", 2, 0);
    tick();
    expect_lit("bringup_ready_e20", 2, 1);
    expect_lit("bringup_sys_rst_e20", 1, 0);
    expect_lit("bringup_retry_e20", 4, 0);

    // relock_req in RUN, then a one-cycle glitch while STABLE.
    g = $urandom_range(0, 4);
    bus.relock_req = 1'b1;
    tick();
    bus.relock_req = 1'b0;
    expect_lit("relock_state", 6, 0);
    tick(3);
    expect_lit("relock_pll_rst_r3", 0, 1);
    tick();
    expect_lit("relock_pll_rst_r4", 0, 0);
    tick(2 + g);
    bus.pll_locked = 1'b0;
    tick();
    bus.pll_locked = 1'b1;
    tick(2);
    expect_lit("glitch_back_to_wait", 6, 1);
    tick(8);
    expect_lit("glitch_ready_early", 2, 0);
    tick();
    expect_lit("glitch_ready", 2, 1);
    expect_lit("relock_lost_unchanged", 5, 0);

    // Loss in RUN, relock_req ignored while waiting, then lock restored.
    bus.pll_locked = 1'b0;
    tick(2);
    expect_lit("loss_ready_d2", 2, 1);
    tick();
    expect_lit("loss_ready_d3", 2, 0);
    expect_lit("loss_sys_rst_d3", 1, 1);
    expect_lit("loss_lost_cnt", 5, 1);
    tick(3);
    expect_lit("loss_pll_rst_d6", 0, 1);
    tick();
    expect_lit("loss_pll_rst_d7", 0, 0);
    tick(2 + $urandom_range(0, 10));
    pulse_relock();
    expect_lit("relock_in_wait_ignored", 6, 1);
    bus.pll_locked = 1'b1;
    wait_state(3, 40, "loss_relock_run");

    // No lock: initial pulse plus two retries, then FAULT.
    bus.pll_locked = 1'b0;
    pulses = 0; maxr = 0; prev = int'(bus.pll_rst);
    for (int i = 0; i < 200; i++) begin
      tick();
      if (bus.pll_rst && prev == 0 && bus.state_o == 3'd0) pulses++;
      prev = int'(bus.pll_rst);
      if (int'(bus.retry_cnt) > maxr) maxr = int'(bus.retry_cnt);
      if (bus.state_o == 3'd4) break;
    end
    expect_lit("nolock_pulses", 7, 3, pulses);
    expect_lit("nolock_max_retry", 7, 2, maxr);
    expect_lit("nolock_fault", 3, 1);
    expect_lit("nolock_state", 6, 4);
    pulse_relock();
    expect_lit("fault_exit_fault", 3, 0);
    expect_lit("fault_exit_retry", 4, 0);
    expect_lit("fault_exit_pll_rst", 0, 1);
    expect_lit("fault_exit_state", 6, 0);
    bus.pll_locked = 1'b1;
    wait_state(3, 40, "fault_recover_run");

    // Random lock noise and software requests.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 29) == 0) bus.pll_locked = ~bus.pll_locked;
      bus.relock_req = ($urandom_range(0, 39) == 0);
      tick();
    end
    bus.relock_req = 1'b0;
    bus.pll_locked = 1'b1;
    pulse_relock();
    wait_state(3, 200, "random_settle_run");

    // Drive lost_cnt into saturation.
    for (int i = 0; i < 260; i++) begin
      bus.pll_locked = 1'b0;
      wait_state(0, 10, "sat_loss");
      tick($urandom_range(0, 3));
      bus.pll_locked = 1'b1;
      wait_state(3, 60, "sat_run");
    end
    expect_lit("lost_saturated", 5, 255);

    // One more loss, then rst asserted between edges in WAIT_LOCK.
    bus.pll_locked = 1'b0;
    wait_state(1, 20, "rst_reach_wait");
    expect_lit("lost_stays_255", 5, 255);
    tick(5);
    #2;
    rst = 1'b1;
    #1;
    expect_lit("async_rst_pll_rst", 0, 1);
    expect_lit("async_rst_sys_rst", 1, 1);
    expect_lit("async_rst_ready", 2, 0);
    expect_lit("async_rst_retry", 4, 0);
    expect_lit("async_rst_lost", 5, 0);
    expect_lit("async_rst_state", 6, 0);
    tick(3);
    rst = 1'b0;
    bus.pll_locked = 1'b1;
    wait_state(3, 60, "post_rst_run");
    expect_lit("post_rst_lost", 5, 0);
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
